// File: rtl/key_gen_pkg.sv
// Shared types for the search key generator: key sequence modes and FSM states.
package key_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/key_step.sv
// Combinational next-key function: increment, decrement, Galois LFSR shift or hold.
module key_step
  import key_gen_pkg::*;
#(
  parameter int                      C_RULE_WIDTH = 24,
  parameter logic [C_RULE_WIDTH-1:0] C_LFSR_POLY  = C_RULE_WIDTH'(24'hE10000)
)(
  input  logic [C_RULE_WIDTH-1:0] key,
  input  mode_e                   mode,
  output logic [C_RULE_WIDTH-1:0] next_key
);

  always_comb begin
    next_key = key;
    case (mode)
      MODE_INC:   next_key = key + C_RULE_WIDTH'(1);
      MODE_DEC:   next_key = key - C_RULE_WIDTH'(1);
      // Left-shifting Galois form: the bit falling off the top folds the taps back in.
      MODE_LFSR:  next_key = {key[C_RULE_WIDTH-2:0], 1'b0}
                             ^ (key[C_RULE_WIDTH-1] ? C_LFSR_POLY : '0);
      MODE_CONST: next_key = key;
      default:    next_key = key;
    endcase
  end

endmodule

// File: rtl/search_key_gen.sv
// Search key generator: issues keys in bursts separated by idle gaps and
// counts issued keys plus hit/miss results returned by the search engine.
module search_key_gen
  import key_gen_pkg::*;
#(
  parameter int                      C_RULE_WIDTH = 24,
  parameter int                      C_NUM_GEN    = 1,
  parameter int                      C_PAUSE      = 16,
  parameter int                      C_CNT_WIDTH  = 16,
  parameter logic [C_RULE_WIDTH-1:0] C_LFSR_POLY  = C_RULE_WIDTH'(24'hE10000)
)(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    strb_start_i,
  input  logic                    strb_stop_i,
  input  logic [1:0]              mode_i,
  input  logic [C_RULE_WIDTH-1:0] seed_i,
  input  logic [C_CNT_WIDTH-1:0]  max_keys_i,
  input  logic                    hit_vd_i,
  input  logic                    hit_i,
  output logic                    search_o,
  output logic [C_RULE_WIDTH-1:0] key_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [C_CNT_WIDTH-1:0]  key_cnt_o,
  output logic [C_CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [C_CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int GW = (C_NUM_GEN > 1) ? $clog2(C_NUM_GEN) : 1;
  localparam int PW = (C_PAUSE > 1) ? $clog2(C_PAUSE) : 1;
  localparam logic [GW-1:0] GEN_LAST   = GW'(C_NUM_GEN - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'((C_PAUSE > 0) ? C_PAUSE - 1 : 0);
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                  state, state_d;
  mode_e                   mode_q;
  logic [C_RULE_WIDTH-1:0] key_q, next_key, seed_eff;
  logic [C_CNT_WIDTH-1:0]  max_q, key_cnt, hit_cnt, miss_cnt;
  logic [GW-1:0]           gen_cnt;
  logic [PW-1:0]           pause_cnt;
  logic                    done_q;
  logic                    load, advance, run_done, last_key;

  key_step #(
    .C_RULE_WIDTH (C_RULE_WIDTH),
    .C_LFSR_POLY  (C_LFSR_POLY)
  ) u_key_step (
    .key      (key_q),
    .mode     (mode_q),
    .next_key (next_key)
  );

  // An all-zero LFSR state would lock up, so a zero seed starts at 1 instead.
  assign seed_eff = (mode_e'(mode_i) == MODE_LFSR && seed_i == '0)
                    ? C_RULE_WIDTH'(1) : seed_i;

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    advance  = 1'b0;
    run_done = 1'b0;
    last_key = (max_q != '0) && (key_cnt == max_q - C_CNT_WIDTH'(1));
    case (state)
      ST_IDLE: begin
        if (strb_start_i && !strb_stop_i) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (strb_stop_i) begin
          state_d = ST_IDLE;
        end else if (last_key) begin
          state_d  = ST_IDLE;
          run_done = 1'b1;
        end else if (gen_cnt == GEN_LAST && C_PAUSE != 0) begin
          state_d = ST_PAUSE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (strb_stop_i) begin
          state_d = ST_IDLE;
        end else if (pause_cnt == PAUSE_LAST) begin
          state_d = ST_ISSUE;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The key only steps when another key follows, so key_o keeps the last issued key.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_INC;
      key_q     <= '0;
      max_q     <= '0;
      gen_cnt   <= '0;
      pause_cnt <= '0;
      done_q    <= 1'b0;
      key_cnt   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state  <= state_d;
      done_q <= run_done;

      if (load) begin
        mode_q  <= mode_e'(mode_i);
        key_q   <= seed_eff;
        max_q   <= max_keys_i;
        gen_cnt <= '0;
      end else if (advance) begin
        key_q <= next_key;
      end

      if (state == ST_ISSUE) begin
        gen_cnt <= (gen_cnt == GEN_LAST) ? '0 : gen_cnt + GW'(1);
      end

      if (state == ST_PAUSE) begin
        pause_cnt <= pause_cnt + PW'(1);
      end else begin
        pause_cnt <= '0;
      end

      if (load) begin
        key_cnt <= '0;
      end else if (state == ST_ISSUE && key_cnt != CNT_MAX) begin
        key_cnt <= key_cnt + C_CNT_WIDTH'(1);
      end

      if (load) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else if (hit_vd_i) begin
        if (hit_i && hit_cnt != CNT_MAX) begin
          hit_cnt <= hit_cnt + C_CNT_WIDTH'(1);
        end
        if (!hit_i && miss_cnt != CNT_MAX) begin
          miss_cnt <= miss_cnt + C_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign search_o   = (state == ST_ISSUE);
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_q;
  assign key_o      = key_q;
  assign key_cnt_o  = key_cnt;
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_search_key_gen.sv
// Directed bench for search_key_gen: a default-parameter instance (1 key per
// burst, 16-cycle gap) and a narrow instance (3-key bursts, no gap, 4-bit counters).
module tb_search_key_gen;
  import key_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic        a_start, a_stop, a_hit_vd, a_hit;
  logic [1:0]  a_mode;
  logic [23:0] a_seed;
  logic [15:0] a_max;
  logic        a_search, a_busy, a_done;
  logic [23:0] a_key;
  logic [15:0] a_kcnt, a_hcnt, a_mcnt;

  logic        b_start, b_stop, b_hit_vd, b_hit;
  logic [1:0]  b_mode;
  logic [23:0] b_seed;
  logic [3:0]  b_max;
  logic        b_search, b_busy, b_done;
  logic [23:0] b_key;
  logic [3:0]  b_kcnt, b_hcnt, b_mcnt;

  search_key_gen #(
    .C_RULE_WIDTH (24), .C_NUM_GEN (1), .C_PAUSE (16), .C_CNT_WIDTH (16),
    .C_LFSR_POLY  (24'hE10000)
  ) dut_a (
    .clk_i (clk), .rstn_i (rstn), .strb_start_i (a_start), .strb_stop_i (a_stop),
    .mode_i (a_mode), .seed_i (a_seed), .max_keys_i (a_max),
    .hit_vd_i (a_hit_vd), .hit_i (a_hit),
    .search_o (a_search), .key_o (a_key), .busy_o (a_busy), .done_o (a_done),
    .key_cnt_o (a_kcnt), .hit_cnt_o (a_hcnt), .miss_cnt_o (a_mcnt)
  );

  search_key_gen #(
    .C_RULE_WIDTH (24), .C_NUM_GEN (3), .C_PAUSE (0), .C_CNT_WIDTH (4),
    .C_LFSR_POLY  (24'hE10000)
  ) dut_b (
    .clk_i (clk), .rstn_i (rstn), .strb_start_i (b_start), .strb_stop_i (b_stop),
    .mode_i (b_mode), .seed_i (b_seed), .max_keys_i (b_max),
    .hit_vd_i (b_hit_vd), .hit_i (b_hit),
    .search_o (b_search), .key_o (b_key), .busy_o (b_busy), .done_o (b_done),
    .key_cnt_o (b_kcnt), .hit_cnt_o (b_hcnt), .miss_cnt_o (b_mcnt)
  );

  typedef struct packed {
    logic [1:0]        mode;
    logic [23:0]       seed;
    logic [15:0]       max;
    logic [3:0][23:0]  keys;
    logic [7:0]        poke;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic [23:0] seed,
                              input logic [15:0] max, input logic [23:0] k0,
                              input logic [23:0] k1, input logic [23:0] k2,
                              input logic [23:0] k3, input logic [7:0] poke);
    vec_t v;
    v.mode    = mode;
    v.seed    = seed;
    v.max     = max;
    v.keys[0] = k0;
    v.keys[1] = k1;
    v.keys[2] = k2;
    v.keys[3] = k3;
    v.poke    = poke;
    return v;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // One limited run on dut_a: keys every 17 cycles, done one cycle after the last key.
  // The inputs are scrambled after the start cycle, and an optional extra start is
  // pulsed mid-run; neither may disturb the sequence.
  task automatic applyStimulus(input vec_t v);
    int n;
    int total;
    int idx;
    logic is_key;
    logic [23:0] last;
    n     = int'(v.max);
    total = 17 * (n - 1) + 2;
    last  = v.keys[0];
    tick();
    a_mode  = v.mode;
    a_seed  = v.seed;
    a_max   = v.max;
    a_start = 1'b1;
    for (int c = 1; c <= total; c++) begin
      tick();
      is_key = ((c - 1) % 17 == 0) && (c < total);
      if (is_key) begin
        idx  = (c - 1) / 17;
        last = v.keys[idx];
      end
      checkOutput("key", a_key, last);
      checkOutput("search", a_search, is_key);
      checkOutput("busy", a_busy, c < total);
      checkOutput("done", a_done, c == total);
      a_start = (c == int'(v.poke));
      a_seed  = 24'h5A5A5A;
      a_mode  = 2'd3;
      a_max   = 16'd1;
    end
    checkOutput("key_cnt", a_kcnt, v.max);
    tick();
    checkOutput("done_pulse", a_done, 1'b0);
    checkOutput("idle_key_hold", a_key, last);
  endtask

  initial begin
    rstn = 1'b0;
    {a_start, a_stop, a_hit_vd, a_hit, a_mode, a_seed, a_max} = '0;
    {b_start, b_stop, b_hit_vd, b_hit, b_mode, b_seed, b_max} = '0;

    vecs[0] = mk(2'd0, 24'h000010, 16'd4, 24'h000010, 24'h000011, 24'h000012, 24'h000013, 8'd0);
    vecs[1] = mk(2'd1, 24'h000001, 16'd3, 24'h000001, 24'h000000, 24'hFFFFFF, 24'h000000, 8'd18);
    vecs[2] = mk(2'd2, 24'h000000, 16'd4, 24'h000001, 24'h000002, 24'h000004, 24'h000008, 8'd5);
    vecs[3] = mk(2'd3, 24'hABCDEF, 16'd2, 24'hABCDEF, 24'hABCDEF, 24'h000000, 24'h000000, 8'd0);
    vecs[4] = mk(2'd2, 24'h800000, 16'd2, 24'h800000, 24'hE10000, 24'h000000, 24'h000000, 8'd0);
    vecs[5] = mk(2'd0, 24'hFFFFFF, 16'd2, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 8'd1);

    tick();
    tick();
    checkOutput("rst_search", a_search, 1'b0);
    checkOutput("rst_busy", a_busy, 1'b0);
    checkOutput("rst_done", a_done, 1'b0);
    checkOutput("rst_key", a_key, 24'h0);
    checkOutput("rst_kcnt", a_kcnt, 16'h0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Stop on the fifth gap cycle, then restart with a new seed.
    tick();
    a_mode = 2'd0; a_seed = 24'h000100; a_max = 16'd0; a_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) checkOutput("stop_first_key", a_key, 24'h000100);
      checkOutput("stop_search", a_search, c == 1);
      checkOutput("stop_busy", a_busy, c <= 6);
      checkOutput("stop_done", a_done, 1'b0);
      a_start = 1'b0;
      a_stop  = (c == 6);
    end
    checkOutput("stop_kcnt_held", a_kcnt, 16'd1);
    checkOutput("stop_key_held", a_key, 24'h000100);
    a_seed = 24'h000200; a_max = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checkOutput("restart_search", a_search, 1'b1);
    checkOutput("restart_key", a_key, 24'h000200);
    tick();
    checkOutput("restart_done", a_done, 1'b1);
    checkOutput("restart_kcnt", a_kcnt, 16'd1);
    tick();

    // Start and stop together in IDLE: stop wins.
    a_start = 1'b1; a_stop = 1'b1;
    tick();
    a_start = 1'b0; a_stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("startstop_busy", a_busy, 1'b0);
      checkOutput("startstop_search", a_search, 1'b0);
      tick();
    end

    // Hit/miss counting while idle, then cleared by a start.
    a_hit_vd = 1'b1;
    a_hit = 1'b1; tick();
    a_hit = 1'b0; tick();
    a_hit = 1'b1; tick();
    a_hit = 1'b1; tick();
    a_hit = 1'b0; tick();
    a_hit_vd = 1'b0;
    checkOutput("hit_cnt_idle", a_hcnt, 16'd3);
    checkOutput("miss_cnt_idle", a_mcnt, 16'd2);
    a_mode = 2'd0; a_seed = 24'h000001; a_max = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checkOutput("hit_cnt_cleared", a_hcnt, 16'd0);
    checkOutput("miss_cnt_cleared", a_mcnt, 16'd0);
    a_hit_vd = 1'b1; a_hit = 1'b1;
    tick();
    a_hit_vd = 1'b0;
    checkOutput("hit_cnt_run", a_hcnt, 16'd1);
    tick();

    // Narrow instance: back-to-back burst wrapping through zero.
    b_mode = 2'd0; b_seed = 24'hFFFFFF; b_max = 4'd3; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checkOutput("b_key0", b_key, 24'hFFFFFF);
    tick();
    checkOutput("b_key1", b_key, 24'h000000);
    checkOutput("b_search1", b_search, 1'b1);
    tick();
    checkOutput("b_key2", b_key, 24'h000001);
    checkOutput("b_search2", b_search, 1'b1);
    tick();
    checkOutput("b_done", b_done, 1'b1);
    checkOutput("b_search_end", b_search, 1'b0);
    checkOutput("b_kcnt", b_kcnt, 4'd3);

    // Unlimited run: continuous issue, key counter saturates at 15.
    b_seed = 24'h0; b_max = 4'd0; b_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      b_start = 1'b0;
      checkOutput("b_cont_search", b_search, 1'b1);
    end
    checkOutput("b_cont_key", b_key, 24'd19);
    checkOutput("b_kcnt_sat", b_kcnt, 4'd15);
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    checkOutput("b_stop_busy", b_busy, 1'b0);

    b_hit_vd = 1'b1; b_hit = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    b_hit = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    b_hit_vd = 1'b0;
    checkOutput("b_hit_sat", b_hcnt, 4'd15);
    checkOutput("b_miss", b_mcnt, 4'd3);

    // Asynchronous reset in the middle of running bursts.
    a_mode = 2'd0; a_seed = 24'h000300; a_max = 16'd0; a_start = 1'b1;
    b_mode = 2'd1; b_seed = 24'h000050; b_max = 4'd0; b_start = 1'b1;
    tick();
    a_start = 1'b0; b_start = 1'b0;
    b_hit_vd = 1'b1; b_hit = 1'b1;
    tick();
    tick();
    b_hit_vd = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_a_search", a_search, 1'b0);
    checkOutput("arst_a_busy", a_busy, 1'b0);
    checkOutput("arst_a_key", a_key, 24'h0);
    checkOutput("arst_a_kcnt", a_kcnt, 16'h0);
    checkOutput("arst_b_search", b_search, 1'b0);
    checkOutput("arst_b_busy", b_busy, 1'b0);
    checkOutput("arst_b_done", b_done, 1'b0);
    checkOutput("arst_b_key", b_key, 24'h0);
    checkOutput("arst_b_kcnt", b_kcnt, 4'h0);
    checkOutput("arst_b_hcnt", b_hcnt, 4'h0);
    checkOutput("arst_b_mcnt", b_mcnt, 4'h0);

    // Start accepted on the first edge after reset release.
    tick();
    rstn = 1'b1;
    a_mode = 2'd0; a_seed = 24'h000042; a_max = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checkOutput("post_rst_search", a_search, 1'b1);
    checkOutput("post_rst_key", a_key, 24'h000042);
    tick();
    checkOutput("post_rst_done", a_done, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
